// File: rtl/raster_engine.sv
// rtl/raster_engine.sv - framebuffer rasterizer with command port and raster scan-out
module raster_engine #(
  parameter int COORD_W = 3,
  parameter int PIX_W   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y1,
  input  logic [PIX_W-1:0]   cmd_color,
  output logic               cmd_done,
  input  logic               scan_en,
  output logic               pix_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [PIX_W-1:0]   pix_data,
  output logic               frame_start
);

  localparam int DEPTH = 1 << (2 * COORD_W);
  localparam logic [COORD_W-1:0] CMAX = '1;
  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_PIXEL = 2'd1;
  localparam logic [1:0] OP_XRECT = 2'd3;

  typedef enum logic {IDLE, DRAW} state_t;

  state_t state, state_nxt;

  logic [PIX_W-1:0]   fb [0:DEPTH-1];
  logic               rst_q;
  logic [1:0]         op_q;
  logic [PIX_W-1:0]   color_q;
  logic [COORD_W-1:0] xl, xh, yl, yh;
  logic [COORD_W-1:0] cx, cy;
  logic [COORD_W-1:0] sx, sy;
  logic [COORD_W-1:0] acc_xl, acc_xh, acc_yl, acc_yh;
  logic               accept;
  logic               last_pix;
  logic [2*COORD_W-1:0] wr_addr;
  logic [2*COORD_W-1:0] rd_addr;

  // Ready is held low for the cycle after any reset edge so it rises only once rst is released.
  assign cmd_ready = (state == IDLE) && !rst_q;
  assign accept    = cmd_valid && cmd_ready;
  // Termination compares the cursor against the far corner, so no pixel counter can overflow.
  assign last_pix  = (cx == xh) && (cy == yh);
  assign wr_addr   = {cy, cx};
  assign rd_addr   = {sy, sx};

  // Normalise the incoming corners according to the op being accepted.
  always_comb begin
    acc_xl = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
    acc_xh = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
    acc_yl = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
    acc_yh = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
    if (cmd_op == OP_CLEAR) begin
      acc_xl = '0;
      acc_xh = CMAX;
      acc_yl = '0;
      acc_yh = CMAX;
    end else if (cmd_op == OP_PIXEL) begin
      acc_xl = cmd_x0;
      acc_xh = cmd_x0;
      acc_yl = cmd_y0;
      acc_yh = cmd_y0;
    end
  end

  // Registered copy of reset used to gate cmd_ready.
  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state: accept moves to DRAW, the final pixel write returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = DRAW;
      DRAW:    if (last_pix) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, draw cursor stepping and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      color_q  <= '0;
      xl       <= '0;
      xh       <= '0;
      yl       <= '0;
      yh       <= '0;
      cx       <= '0;
      cy       <= '0;
      cmd_done <= 1'b0;
    end else begin
      cmd_done <= (state == DRAW) && last_pix;
      if (accept) begin
        op_q    <= cmd_op;
        color_q <= cmd_color;
        xl      <= acc_xl;
        xh      <= acc_xh;
        yl      <= acc_yl;
        yh      <= acc_yh;
        cx      <= acc_xl;
        cy      <= acc_yl;
      end else if (state == DRAW && !last_pix) begin
        if (cx == xh) begin
          cx <= xl;
          cy <= cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
        end
      end
    end
  end

  // Framebuffer write port: plain fill or read-modify-write XOR at the cursor.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) fb[i] <= '0;
    end else if (state == DRAW) begin
      if (op_q == OP_XRECT) fb[wr_addr] <= fb[wr_addr] ^ color_q;
      else                  fb[wr_addr] <= color_q;
    end
  end

  // Scan-out: read the pre-write pixel at the counter and advance row-major while enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      sx          <= '0;
      sy          <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= '0;
      frame_start <= 1'b0;
    end else if (scan_en) begin
      pix_valid   <= 1'b1;
      pix_x       <= sx;
      pix_y       <= sy;
      pix_data    <= fb[rd_addr];
      frame_start <= (sx == '0) && (sy == '0);
      sx          <= sx + 1'b1;
      if (sx == CMAX) sy <= sy + 1'b1;
    end
  end

endmodule

// File: doc/raster_engine.md
# raster_engine

Parametrised successor to the fixed 8x8 rasterizer. It owns a square 2^COORD_W x 2^COORD_W framebuffer of PIX_W-bit pixels and accepts drawing commands over a valid/ready handshake: clear, single pixel, filled rectangle and XOR rectangle. Drawing is one pixel per cycle. An independent raster scan-out port streams the framebuffer continuously for the output pins or a display adapter. It sits between the command decoder and the chip-level output mux.

## Interface
Parameters:
- COORD_W, default 3: coordinate width; framebuffer is 2^COORD_W square (3 gives 8x8, 4 gives 16x16).
- PIX_W, default 1: bits per pixel.

Ports (clock and reset first):
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_op  in  2  0 CLEAR, 1 PIXEL, 2 RECT, 3 XRECT.
- cmd_x0, cmd_y0  in  COORD_W each  first corner / pixel position.
- cmd_x1, cmd_y1  in  COORD_W each  opposite corner (RECT/XRECT only).
- cmd_color  in  PIX_W  fill colour; XOR mask for XRECT.
- cmd_done  out  1  one-cycle pulse when a command completes.
- scan_en  in  1  scan-out counters advance while high.
- pix_valid  out  1  pix_data/pix_x/pix_y are meaningful.
- pix_x, pix_y  out  COORD_W each  coordinate of pix_data.
- pix_data  out  PIX_W  framebuffer contents at (pix_x, pix_y).
- frame_start  out  1  high together with pixel (0,0).

## Operation
States:
- IDLE: cmd_ready=1.
- DRAW: cmd_ready=0.

Command acceptance:
- A command is accepted on a clk edge where cmd_valid & cmd_ready.
- On acceptance, the engine latches the op and colour, and latches the corners normalised: xl=min(x0,x1), xh=max(x0,x1), and likewise for y.
- PIXEL uses xl=xh=x0 and yl=yh=y0.
- CLEAR uses the full range 0..2^COORD_W-1.
- cmd_x1/cmd_y1 are ignored for PIXEL and CLEAR.

DRAW state:
- Cursor starts at (xl,yl) and writes one pixel per cycle in row-major order, x fastest.
- At x==xh the cursor wraps x to xl and increments y.
- The pixel at (xh,yh) is the last write, then the engine returns to IDLE.
- CLEAR, PIXEL, RECT write fb = cmd_color.
- XRECT writes fb = fb ^ cmd_color, read-modify-write in the same cycle.
- Pixel count = (xh-xl+1)*(yh-yl+1). Counter arithmetic must not overflow at full range: CLEAR at COORD_W=4 is 256 writes.

Scan-out:
- Free-running sx/sy counters, row-major, advance only while scan_en=1.
- sx wraps 2^COORD_W-1 -> 0 and increments sy; sy wraps to 0 after the last row.
- The registered outputs present fb[sy][sx] with pix_x=sx and pix_y=sy.
- frame_start=1 exactly when the presented coordinate is (0,0) and pix_valid=1.

Write/read collision:
- If scan-out reads the pixel being drawn in the same cycle, it returns the pre-write value.
- No stall is applied in either direction.

Reset:
- While rst=1: state IDLE; cmd_ready=0, cmd_done=0, pix_valid=0, frame_start=0, pix_x=pix_y=0, pix_data=0.
- All framebuffer pixels and scan counters clear to 0.
- rst asserted mid-DRAW aborts the command with no cmd_done.

## Timing
- cmd_ready rises the first cycle after rst deasserts.
- The command accepted at edge T performs its first write at edge T+1 and its last write at edge T+N.
- cmd_ready is low for cycles T+1..T+N and high again after edge T+N. A back-to-back command is accepted at edge T+N+1 at the earliest.
- cmd_done is high for one cycle after edge T+N, coincident with cmd_ready returning high.
- A PIXEL command has N=1: ready is low for one cycle.
- cmd_valid without ready: the master holds the command stable; the engine samples only on handshake.
- Scan-out latency is 1 cycle: the coordinate counter value at edge S appears on the pix_* outputs after edge S+1.
- pix_valid is set one cycle after scan_en is first seen high and stays high thereafter, including while scan_en is low; outputs hold when scan_en=0.

## Test plan
- Reset then idle, default params: all outputs 0 during rst. cmd_ready=1 one cycle after release. With scan_en=1, 64 pixels of 0 are read, with frame_start on (0,0) every 64 cycles.
- PIXEL (5,2) colour 1: ready low exactly 1 cycle, cmd_done pulse. Next frame shows only pix (5,2)=1.
- RECT with reversed corners (6,5)->(1,3), colour 1: 18 cycles busy. Exactly x=1..6, y=3..5 read back as 1; all other pixels 0.
- XRECT (0,0)->(7,7) mask 1 applied over the previous picture: the image is inverted, 64 busy cycles. A second identical XRECT restores the original image.
- COORD_W=4, PIX_W=4: CLEAR colour 4'hA gives 256 busy cycles and every pixel reads 0xA. A back-to-back PIXEL issued with valid held high is accepted at edge T+257.
- rst pulsed at cycle 10 of a 64-pixel CLEAR: no cmd_done. The framebuffer reads all 0 and cmd_ready returns 1 cycle after release.
